// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS core: opcodes, ALU-op classes
// and the packed control bundle that travels down the pipeline.
package mips_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'd0;
  localparam logic [OPCODE_W-1:0] OP_IMM1   = 6'd1;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 6'd4;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 6'd5;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 6'd6;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 6'd7;

  localparam int ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OP_BRCMP = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_OP_IMM1  = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OP_MEM   = 3'd3;

  typedef struct packed {
    logic                reg_dst;
    logic                alu_src;
    logic                mem_to_reg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam ctrl_t CTRL_BUBBLE = 10'b0;

  // rt is a source operand for R-type, stores and branch compares.
  function automatic logic rt_in_use(input ctrl_t c);
    return c.reg_dst | c.mem_write | c.branch;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use hazard detector between the load in EX and the
// instruction currently in ID.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_reg_dst,
  input  logic             id_mem_write,
  input  logic             id_branch,
  output logic             hazard_raw
);

  logic  load_in_ex_s;
  logic  rs_match_s;
  logic  rt_match_s;
  ctrl_t id_use_s;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  always_comb begin
    id_use_s           = CTRL_BUBBLE;
    id_use_s.reg_dst   = id_reg_dst;
    id_use_s.mem_write = id_mem_write;
    id_use_s.branch    = id_branch;
    load_in_ex_s = ex_valid & ex_mem_read & (ex_rt != {REG_W{1'b0}});
    rs_match_s   = (ex_rt == id_rs);
    rt_match_s   = (ex_rt == id_rt) & rt_in_use(id_use_s);
    if (load_in_ex_s && id_valid) begin
      hazard_raw = rs_match_s | rt_match_s;
    end else begin
      hazard_raw = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/hold
// handling and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_branch,
  input  logic [2:0]        id_alu_op,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic              flush,
  input  logic              ex_hold,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic [2:0]        ex_alu_op,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    UPD_CAPTURE = 2'd0,
    UPD_HOLD    = 2'd1,
    UPD_BUBBLE  = 2'd2
  } upd_e;

  ctrl_t             id_ctrl_s;
  ctrl_t             ex_ctrl_r;
  logic              ex_valid_r;
  logic [REG_W-1:0]  ex_rs_r;
  logic [REG_W-1:0]  ex_rt_r;
  logic [REG_W-1:0]  ex_rd_r;
  logic [DATA_W-1:0] ex_rdata1_r;
  logic [DATA_W-1:0] ex_rdata2_r;
  logic [DATA_W-1:0] ex_imm_r;
  logic [DATA_W-1:0] ex_pc4_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic              hazard_raw_s;
  upd_e              upd_s;
  logic              count_s;

  // Bundle the decoded control bits so they move as one field.
  always_comb begin
    id_ctrl_s            = CTRL_BUBBLE;
    id_ctrl_s.reg_dst    = id_reg_dst;
    id_ctrl_s.alu_src    = id_alu_src;
    id_ctrl_s.mem_to_reg = id_mem_to_reg;
    id_ctrl_s.reg_write  = id_reg_write;
    id_ctrl_s.mem_read   = id_mem_read;
    id_ctrl_s.mem_write  = id_mem_write;
    id_ctrl_s.branch     = id_branch;
    id_ctrl_s.alu_op     = id_alu_op;
  end

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ex_valid     (ex_valid_r),
    .ex_mem_read  (ex_ctrl_r.mem_read),
    .ex_rt        (ex_rt_r),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_reg_dst   (id_reg_dst),
    .id_mem_write (id_mem_write),
    .id_branch    (id_branch),
    .hazard_raw   (hazard_raw_s)
  );

  // Priority: flush over hold over load-use hazard over normal capture.
  always_comb begin
    upd_s = UPD_CAPTURE;
    if (flush) begin
      upd_s = UPD_BUBBLE;
    end else if (ex_hold) begin
      upd_s = UPD_HOLD;
    end else if (hazard_raw_s) begin
      upd_s = UPD_BUBBLE;
    end else begin
      upd_s = UPD_CAPTURE;
    end
    count_s = (upd_s == UPD_BUBBLE) & id_valid;
    stall   = hazard_raw_s & ~flush & ~ex_hold;
  end

  // Pipeline register: a bubble zeroes every field, never keeps stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_r  <= 1'b0;
      ex_ctrl_r   <= CTRL_BUBBLE;
      ex_rs_r     <= {REG_W{1'b0}};
      ex_rt_r     <= {REG_W{1'b0}};
      ex_rd_r     <= {REG_W{1'b0}};
      ex_rdata1_r <= {DATA_W{1'b0}};
      ex_rdata2_r <= {DATA_W{1'b0}};
      ex_imm_r    <= {DATA_W{1'b0}};
      ex_pc4_r    <= {DATA_W{1'b0}};
    end else begin
      case (upd_s)
        UPD_BUBBLE: begin
          ex_valid_r  <= 1'b0;
          ex_ctrl_r   <= CTRL_BUBBLE;
          ex_rs_r     <= {REG_W{1'b0}};
          ex_rt_r     <= {REG_W{1'b0}};
          ex_rd_r     <= {REG_W{1'b0}};
          ex_rdata1_r <= {DATA_W{1'b0}};
          ex_rdata2_r <= {DATA_W{1'b0}};
          ex_imm_r    <= {DATA_W{1'b0}};
          ex_pc4_r    <= {DATA_W{1'b0}};
        end
        UPD_CAPTURE: begin
          ex_valid_r  <= id_valid;
          ex_ctrl_r   <= id_ctrl_s;
          ex_rs_r     <= id_rs;
          ex_rt_r     <= id_rt;
          ex_rd_r     <= id_rd;
          ex_rdata1_r <= id_rdata1;
          ex_rdata2_r <= id_rdata2;
          ex_imm_r    <= id_imm;
          ex_pc4_r    <= id_pc4;
        end
        UPD_HOLD: begin
          ex_valid_r  <= ex_valid_r;
          ex_ctrl_r   <= ex_ctrl_r;
        end
        default: begin
          ex_valid_r  <= 1'b0;
          ex_ctrl_r   <= CTRL_BUBBLE;
        end
      endcase
    end
  end

  // Saturating bubble counter for performance monitoring.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if (count_s && (bubble_cnt_r != CNT_MAX)) begin
      bubble_cnt_r <= bubble_cnt_r + CNT_ONE;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign ex_valid      = ex_valid_r;
  assign ex_reg_dst    = ex_ctrl_r.reg_dst;
  assign ex_alu_src    = ex_ctrl_r.alu_src;
  assign ex_mem_to_reg = ex_ctrl_r.mem_to_reg;
  assign ex_reg_write  = ex_ctrl_r.reg_write;
  assign ex_mem_read   = ex_ctrl_r.mem_read;
  assign ex_mem_write  = ex_ctrl_r.mem_write;
  assign ex_branch     = ex_ctrl_r.branch;
  assign ex_alu_op     = ex_ctrl_r.alu_op;
  assign ex_rs         = ex_rs_r;
  assign ex_rt         = ex_rt_r;
  assign ex_rd         = ex_rd_r;
  assign ex_rdata1     = ex_rdata1_r;
  assign ex_rdata2     = ex_rdata2_r;
  assign ex_imm        = ex_imm_r;
  assign ex_pc4        = ex_pc4_r;
  assign bubble_cnt    = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a record-level reference model checked
// every cycle, plus literal checks pinning key points of the sequence.
module tb_id_ex_stage;

  localparam logic [9:0] C_RTYPE = 10'b1001000_000;
  localparam logic [9:0] C_LW    = 10'b0111100_011;
  localparam logic [9:0] C_SW    = 10'b0100010_011;
  localparam logic [9:0] C_ADDI  = 10'b0101000_010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0;
  logic [9:0] id_ctrl = 10'b0;
  logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic [31:0] id_rdata1 = 32'd0, id_rdata2 = 32'd0, id_imm = 32'd0, id_pc4 = 32'd0;
  logic flush = 1'b0, ex_hold = 1'b0;

  logic stall, ex_valid, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write;
  logic ex_mem_read, ex_mem_write, ex_branch;
  logic [2:0] ex_alu_op;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  logic [15:0] bubble_cnt;

  logic s_stall, s_valid, s_reg_dst, s_alu_src, s_mem_to_reg, s_reg_write;
  logic s_mem_read, s_mem_write, s_branch;
  logic [2:0] s_alu_op;
  logic [4:0] s_rs, s_rt, s_rd;
  logic [31:0] s_rdata1, s_rdata2, s_imm, s_pc4;
  logic [1:0] s_cnt;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_dst(id_ctrl[9]), .id_alu_src(id_ctrl[8]), .id_mem_to_reg(id_ctrl[7]),
    .id_reg_write(id_ctrl[6]), .id_mem_read(id_ctrl[5]), .id_mem_write(id_ctrl[4]),
    .id_branch(id_ctrl[3]), .id_alu_op(id_ctrl[2:0]),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .flush(flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
    .ex_reg_dst(ex_reg_dst), .ex_alu_src(ex_alu_src), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
    .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_reg_dst(id_ctrl[9]), .id_alu_src(id_ctrl[8]), .id_mem_to_reg(id_ctrl[7]),
    .id_reg_write(id_ctrl[6]), .id_mem_read(id_ctrl[5]), .id_mem_write(id_ctrl[4]),
    .id_branch(id_ctrl[3]), .id_alu_op(id_ctrl[2:0]),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_pc4(id_pc4),
    .flush(flush), .ex_hold(ex_hold), .stall(s_stall), .ex_valid(s_valid),
    .ex_reg_dst(s_reg_dst), .ex_alu_src(s_alu_src), .ex_mem_to_reg(s_mem_to_reg),
    .ex_reg_write(s_reg_write), .ex_mem_read(s_mem_read), .ex_mem_write(s_mem_write),
    .ex_branch(s_branch), .ex_alu_op(s_alu_op),
    .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd),
    .ex_rdata1(s_rdata1), .ex_rdata2(s_rdata2), .ex_imm(s_imm), .ex_pc4(s_pc4),
    .bubble_cnt(s_cnt)
  );

  // Reference model: the instruction record that should sit in EX.
  typedef struct {
    bit       valid;
    bit [9:0] ctrl;
    bit [4:0] rs, rt, rd;
    bit [31:0] r1, r2, imm, pc4;
  } rec_t;

  rec_t m;
  int   m_cnt;

  function automatic bit model_hazard();
    bit rt_used;
    rt_used = id_ctrl[9] | id_ctrl[4] | id_ctrl[3];
    return m.valid && m.ctrl[5] && (m.rt != 5'd0) && id_valid &&
           ((m.rt == id_rs) || ((m.rt == id_rt) && rt_used));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m = '{default: 0};
      m_cnt = 0;
    end else if (flush || (!ex_hold && model_hazard())) begin
      if (id_valid) m_cnt = m_cnt + 1;
      m = '{default: 0};
    end else if (!ex_hold) begin
      m.valid = id_valid; m.ctrl = id_ctrl;
      m.rs = id_rs; m.rt = id_rt; m.rd = id_rd;
      m.r1 = id_rdata1; m.r2 = id_rdata2; m.imm = id_imm; m.pc4 = id_pc4;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("stall", {63'd0, stall}, {63'd0, (model_hazard() && !flush && !ex_hold)});
    check("valid", {63'd0, ex_valid}, {63'd0, m.valid});
    check("ctrl", {54'd0, ex_reg_dst, ex_alu_src, ex_mem_to_reg, ex_reg_write,
                   ex_mem_read, ex_mem_write, ex_branch, ex_alu_op}, {54'd0, m.ctrl});
    check("regs", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, m.rs, m.rt, m.rd});
    check("rdata", {ex_rdata1, ex_rdata2}, {m.r1, m.r2});
    check("imm_pc4", {ex_imm, ex_pc4}, {m.imm, m.pc4});
    check("cnt", {48'd0, bubble_cnt}, 64'(m_cnt > 65535 ? 65535 : m_cnt));
    check("cnt_sat", {62'd0, s_cnt}, 64'(m_cnt > 3 ? 3 : m_cnt));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [9:0] c, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] imm, input logic [31:0] pc4);
    id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_pc4 = pc4;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", {63'd0, ex_valid}, 64'd0);
    check("rst_cnt", {48'd0, bubble_cnt}, 64'd0);

    // Pass-through R-type.
    drive(1'b1, C_RTYPE, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0, 32'h104);
    tick(); #1;
    check("pt_valid", {63'd0, ex_valid}, 64'd1);
    check("pt_regs", {49'd0, ex_rs, ex_rt, ex_rd}, {49'd0, 5'd3, 5'd4, 5'd5});
    check("pt_data", {ex_rdata1, ex_rdata2}, {32'h11, 32'h22});
    check("pt_stall", {63'd0, stall}, 64'd0);

    // Load-use: lw rt=8 then R-type reading r8.
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h40, 32'h0, 32'h8, 32'h108);
    tick();
    drive(1'b1, C_RTYPE, 5'd8, 5'd4, 5'd6, 32'h33, 32'h44, 32'h0, 32'h10c);
    #1 check("lu_stall", {63'd0, stall}, 64'd1);
    tick(); #1;
    check("lu_bubble", {63'd0, ex_valid, ex_rt, ex_rdata1}, 64'd0);
    check("lu_cnt", {48'd0, bubble_cnt}, 64'd1);
    check("lu_stall_drop", {63'd0, stall}, 64'd0);
    tick(); #1;
    check("lu_capture", {59'd0, ex_rs}, 64'd8);

    // Load to r0 never stalls.
    drive(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h40, 32'h0, 32'h8, 32'h110);
    tick();
    drive(1'b1, C_RTYPE, 5'd0, 5'd4, 5'd6, 32'h0, 32'h44, 32'h0, 32'h114);
    #1 check("r0_stall", {63'd0, stall}, 64'd0);
    tick();

    // rt-use filter: addi writes rt, sw reads it.
    drive(1'b1, C_LW, 5'd1, 5'd9, 5'd0, 32'h50, 32'h0, 32'h4, 32'h118);
    tick();
    drive(1'b1, C_ADDI, 5'd2, 5'd9, 5'd0, 32'h7, 32'h0, 32'h5, 32'h11c);
    #1 check("addi_stall", {63'd0, stall}, 64'd0);
    tick();
    drive(1'b1, C_LW, 5'd1, 5'd9, 5'd0, 32'h50, 32'h0, 32'h4, 32'h120);
    tick();
    drive(1'b1, C_SW, 5'd2, 5'd9, 5'd0, 32'h7, 32'h99, 32'hc, 32'h124);
    #1 check("sw_stall", {63'd0, stall}, 64'd1);
    tick(); tick();

    // Flush beats hazard.
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h60, 32'h0, 32'h0, 32'h128);
    tick();
    drive(1'b1, C_RTYPE, 5'd8, 5'd3, 5'd7, 32'h1, 32'h2, 32'h0, 32'h12c);
    flush = 1'b1;
    #1 check("fl_stall", {63'd0, stall}, 64'd0);
    tick();
    flush = 1'b0;
    #1 check("fl_cnt", {48'd0, bubble_cnt}, 64'd3);
    tick();

    // Hold beats hazard, hazard returns after hold drops.
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h70, 32'h0, 32'h0, 32'h130);
    tick();
    drive(1'b1, C_RTYPE, 5'd8, 5'd3, 5'd7, 32'h1, 32'h2, 32'h0, 32'h134);
    ex_hold = 1'b1;
    #1 check("hold_stall", {63'd0, stall}, 64'd0);
    tick(); #1;
    check("hold_keep", {58'd0, ex_mem_read, ex_rt}, {58'd0, 1'b1, 5'd8});
    ex_hold = 1'b0;
    #1 check("hold_rehaz", {63'd0, stall}, 64'd1);
    tick(); tick();

    // Flush with no instruction in ID: bubble, no count.
    drive(1'b0, 10'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 check("fl_inv_cnt", {48'd0, bubble_cnt}, 64'd4);

    // Fifth counted bubble: narrow counter pinned at 3.
    drive(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 32'h138);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 check("sat_wide", {48'd0, bubble_cnt}, 64'd5);
    check("sat_narrow", {62'd0, s_cnt}, 64'd3);
    tick();

    // Reset in the middle of a hold with a pending hazard.
    drive(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 32'h80, 32'h0, 32'h0, 32'h13c);
    tick();
    drive(1'b1, C_RTYPE, 5'd8, 5'd3, 5'd7, 32'h1, 32'h2, 32'h0, 32'h140);
    ex_hold = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst_ex", {26'd0, ex_valid, ex_mem_read, ex_rt, ex_rdata1}, 64'd0);
    check("arst_cnt", {48'd0, bubble_cnt}, 64'd0);
    check("arst_stall", {63'd0, stall}, 64'd0);
    tick();
    rst = 1'b0;
    ex_hold = 1'b0;
    #1 check("post_rst_stall", {63'd0, stall}, 64'd0);
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS core. It registers the decoded control bundle from the control unit together with operands, immediate, register specifiers and PC+4. It detects load-use hazards and inserts bubbles, honours flushes from branch resolution and holds from downstream stalls. It also keeps a saturating count of inserted bubbles for performance monitoring.

## Interface
Parameters:
- DATA_W, 32, width of operands, immediate, PC+4
- REG_W, 5, register specifier width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_read, id_mem_write, id_branch  in  1 each  control bits from control unit
- id_alu_op  in  3  ALU op class: 0 R-type, 1 branch-compare, 2 opcode-1 immediate op, 3 memory/other immediate
- id_rs, id_rt, id_rd  in  REG_W  register specifiers
- id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  operands, sign-extended immediate, PC+4
- flush  in  1  branch taken in a later stage; kill the instruction entering EX
- ex_hold  in  1  downstream stall; EX register must not change
- stall  out  1  combinational; upstream (PC, IF/ID) must hold this cycle
- ex_valid plus registered copies ex_* of every id_* input above  out  same widths
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

## Operation
- Load-use hazard (hazard_raw) is true when all of these hold:
  - ex_valid = 1 and ex_mem_read = 1
  - ex_rt ≠ 0
  - id_valid = 1
  - ex_rt == id_rs, or ex_rt == id_rt with id_rt in use
- id_rt is in use when id_reg_dst = 1 (R-type), id_mem_write = 1 or id_branch = 1.
- stall = hazard_raw & ~flush & ~ex_hold.
- Per-cycle update, in priority order:
  1. flush: load bubble.
  2. ex_hold: keep all ex_* unchanged. stall is 0; upstream is already frozen by the same hold.
  3. hazard_raw: load bubble; stall = 1.
  4. Otherwise: capture all id_* into ex_*. ex_valid = id_valid.
- Bubble: ex_valid and every ex_* field, control and data, are 0. A bubble is never merely a held stale value.
- bubble_cnt increments by 1 whenever a bubble is loaded by rule 1 or 3 while id_valid = 1. It saturates at 2^CNT_W−1 and never wraps.
- Flush with id_valid = 0 loads a bubble but does not count.
- Flush and hazard in the same cycle: flush wins, stall = 0, the counter increments once.
- Hold and hazard in the same cycle: hold wins and stall = 0. The hazard re-evaluates after the hold drops.

## Timing
- Reset (async assert, sync release): every ex_* output = 0, ex_valid = 0, bubble_cnt = 0. stall = 0 because ex_valid = 0.
- Latency: one cycle from id_* to ex_*.
- Load-use costs exactly one bubble cycle. The cycle after the bubble, ex_mem_read = 0, so stall drops and the held instruction is captured.
- Back-to-back loads where the second depends on the first: one bubble only.
- stall is purely combinational from ex_* and id_* registers/inputs. There is no combinational path from flush into ex_* outputs.
- Reset asserted mid-hold or mid-stall clears state immediately. No hazard persists across reset.

## Structure
- Shared package mips_pkg holds:
  - opcode constants (R-type 0, op-1 immediate 1, load 4, store 5, branch 6, immediate 7)
  - ALU-op encodings 0–3
  - a packed control-bundle typedef (7 bits + 3-bit alu_op) and its all-zero BUBBLE constant
- One sub-module, hazard_detect (combinational): inputs ex_valid, ex_mem_read, ex_rt, id_valid, id_rs, id_rt and rt-use bits; output hazard_raw.
- Everything else, including the register, priority mux and counter, lives in id_ex_stage.

## Test plan
- Reset: assert rst mid-stream with non-zero ex_* → all outputs 0 asynchronously; bubble_cnt = 0.
- Pass-through: R-type (reg_dst = 1, reg_write = 1, alu_op = 0, rs = 3, rt = 4, rd = 5, rdata1 = 0x11, rdata2 = 0x22) → identical ex_* next cycle, ex_valid = 1, stall = 0.
- Load-use: lw rt = 8 in EX, then R-type with rs = 8 in ID → stall = 1 for one cycle, ex_* all 0, bubble_cnt 0→1; next cycle the R-type is captured with stall = 0. The same pattern with ex_rt = 0 → no stall.
- rt-use filter: lw rt = 9 in EX; ID = addi (opcode 1, rt = 9 as destination, rs = 2) → no stall. ID = sw with rt = 9 → stall.
- Flush vs hazard: hazard condition plus flush = 1 in the same cycle → stall = 0, bubble loaded, counter +1 once. hold = 1 with hazard → ex_* unchanged, stall = 0.
- Saturation: CNT_W = 2, force 5 counted bubbles → bubble_cnt reads 3 and stays at 3.
